clk_div_multi: RTL and testbench
================================

Name: clk_div_multi

Overview:
- Parametrised, multi-channel successor to the team's fixed 1 Hz divider.
- Each channel derives a 50%-duty divided clock plus a one-cycle tick strobe from the system clock.
- Each channel's half-period is programmable at runtime through a valid/ready config port, with glitch-free switchover.
- Feeds seven-segment scan, debounce sampling and game-timer logic from one shared block.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- CNT_W, 26, width of each half-period counter and config value.
- DEFAULT_HALF, 50000000, reset half-period for every channel (1 Hz at 100 MHz).
- CH_W, clog2(NUM_CH) min 1, width of cfg_ch (derived, not overridden).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous active-low reset
- en  in  NUM_CH  per-channel run enable
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write can be accepted this cycle
- cfg_ch  in  CH_W  target channel of config write
- cfg_half  in  CNT_W  new half-period in clk cycles; 0 is treated as 1
- clk_out  out  NUM_CH  divided clocks, registered
- tick  out  NUM_CH  one-cycle pulse on each clk_out toggle, registered

Behaviour:
- Reset (rst=0, async):
  - cnt[i]=1, half[i]=DEFAULT_HALF, pend[i]=0, clk_out=0, tick=0.
  - cfg_ready falls to 0 on reset assertion.
- Per-channel registers: cnt[i] (CNT_W), active half[i], shadow shd[i], pending flag pend[i].
- Channel i, en[i]=1, each posedge:
  - If cnt[i] >= half[i]: cnt[i]<=1, clk_out[i] toggles, tick[i]<=1.
  - Otherwise: cnt[i]<=cnt[i]+1, tick[i]<=0.
  - Result: output period = 2*half[i] cycles.
  - First toggle occurs half[i] cycles after the first enabled edge.
  - half=1 gives clk/2 with tick high every cycle.
- Channel i, en[i]=0, each posedge:
  - cnt[i]<=1, clk_out[i]<=0, tick[i]<=0.
  - Re-enable restarts from phase 0.
- Comparison uses >= so that shrinking half never runs the counter past the terminal count.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready.
  - cfg_ready = ~pend[cfg_ch] when cfg_ch < NUM_CH, else 1 (out-of-range writes accepted and dropped).
  - cfg_ready is combinational from cfg_ch and pend.
- Accepted write, target channel disabled (en=0): half[ch] <= max(cfg_half,1) on the same edge; pend unchanged (0).
- Accepted write, target channel enabled:
  - shd[ch] <= max(cfg_half,1), pend[ch] <= 1.
  - At the next edge where cnt>=half (the terminal edge), or at the first edge with en=0: half<=shd, pend<=0.
  - The in-flight half-period always completes with the old value; no runt pulse.
- Simultaneous terminal edge and acceptance: the terminal edge uses the old half; the new value goes to shd and applies at the following terminal edge.
- Pending channel, en drops: shd is applied on that edge; clk_out is forced 0.
- Channels are fully independent; writes to one channel never disturb the others.
- Reset mid-operation: all state returns immediately to reset values; any pending write is discarded.
- cnt is never 0 outside arithmetic; no overflow, because half <= 2^CNT_W - 1.

Test Plan:
- Defaults: rst low 3 cycles, release, en=4'b0001, DEFAULT_HALF overridden to 5 -> clk_out[0] rises at enabled edge 5, falls at 10, period 10; tick[0] high exactly on those edges; other channels stay 0.
- Disabled write: en[1]=0, write ch1 half=3, then en[1]=1 -> cfg_ready stays 1; clk_out[1] toggles every 3 cycles from the 3rd enabled edge.
- Glitch-free update:
  - Channel 0 running with half=5, write half=2 at cnt=2 -> cfg_ready for ch0 low until the terminal edge.
  - Remaining old half completes (toggle at cnt=5), then toggles every 2 cycles.
  - A second write to ch0 held on cfg_valid is stalled until pend clears, then accepted.
- Edge cases:
  - Write cfg_half=0 -> behaves as half=1 (clk/2, tick every cycle).
  - Write to cfg_ch=NUM_CH (with NUM_CH=5) -> accepted, no channel changes.
  - Write landing exactly on the terminal edge -> old half used for the current period, new half from the next.
- Enable/reset disruption:
  - Drop en[2] mid-period with a pending write -> clk_out[2]=0 next edge, pend cleared, new half used on re-enable.
  - Assert rst asynchronously mid-count -> all outputs 0 without waiting for clk; after release every channel uses DEFAULT_HALF.

Source files
------------

// File: rtl/clk_div_multi.sv
// Multi-channel 50%-duty clock divider with per-channel tick strobes.
// Each channel's half-period can be reprogrammed at runtime and switches only on a period boundary.
module clk_div_multi #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 26,
    parameter int DEFAULT_HALF = 50000000,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEFAULT_HALF);

    logic [CNT_W-1:0]  cnt  [NUM_CH];
    logic [CNT_W-1:0]  half [NUM_CH];
    logic [CNT_W-1:0]  shd  [NUM_CH];
    logic [NUM_CH-1:0] pend;

    logic [NUM_CH-1:0] sel;
    logic [NUM_CH-1:0] accept;
    logic [CNT_W-1:0]  cfg_val;

    // An out-of-range cfg_ch matches no channel, so it is accepted and silently dropped.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel[i] = (cfg_ch == CH_W'(i));
        end
        // NOTE: gating with rst drops cfg_ready asynchronously while reset is held.
        cfg_ready = rst & ~(|(pend & sel));
        accept    = (cfg_valid && cfg_ready) ? sel : '0;
        cfg_val   = (cfg_half == '0) ? ONE : cfg_half;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]  <= ONE;
                half[i] <= DEF_HALF;
                shd[i]  <= DEF_HALF;
            end
            pend    <= '0;
            clk_out <= '0;
            tick    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!en[i]) begin
                    // Idle channel: park at phase 0 and commit any pending or fresh half-period now.
                    cnt[i]     <= ONE;
                    clk_out[i] <= 1'b0;
                    tick[i]    <= 1'b0;
                    if (pend[i]) begin
                        half[i] <= shd[i];
                        pend[i] <= 1'b0;
                    end else if (accept[i]) begin
                        half[i] <= cfg_val;
                    end
                end else begin
                    // >= keeps a shrunk half-period from letting cnt run past terminal.
                    if (cnt[i] >= half[i]) begin
                        cnt[i]     <= ONE;
                        clk_out[i] <= ~clk_out[i];
                        tick[i]    <= 1'b1;
                        if (pend[i]) begin
                            half[i] <= shd[i];
                            pend[i] <= 1'b0;
                        end
                    end else begin
                        cnt[i]  <= cnt[i] + ONE;
                        tick[i] <= 1'b0;
                    end
                    // accept implies pend was clear, so this never collides with the commit above.
                    if (accept[i]) begin
                        shd[i]  <= cfg_val;
                        pend[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: a behavioural channel model queues expected outputs per edge,
// the monitor pops and compares them after each edge, alongside directed timing checks.
module tb_clk_div_multi;

    localparam int NCH   = 5;
    localparam int CW    = 8;
    localparam int DEFH  = 5;
    localparam int CHW   = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] en;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_half;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;

    int n_checks = 0;
    int n_errors = 0;

    int m_cnt  [NCH];
    int m_half [NCH];
    int m_shd  [NCH];
    bit m_pend [NCH];
    bit m_clk  [NCH];

    logic [2*NCH-1:0] sb [$];

    always #5 clk = ~clk;

    clk_div_multi #(
        .NUM_CH      (NCH),
        .CNT_W       (CW),
        .DEFAULT_HALF(DEFH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_half (cfg_half),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i]  = 1;
            m_half[i] = DEFH;
            m_shd[i]  = DEFH;
            m_pend[i] = 1'b0;
            m_clk[i]  = 1'b0;
        end
    endtask

    function automatic bit model_ready();
        if (!rst) return 1'b0;
        if (int'(cfg_ch) < NCH) return !m_pend[cfg_ch];
        return 1'b1;
    endfunction

    // One clock: check handshake, advance the model, queue expectation, compare after the edge.
    task automatic cycle();
        bit             rdy;
        logic [NCH-1:0] e_clk;
        logic [NCH-1:0] e_tick;
        logic [2*NCH-1:0] exp_v;
        int             v;
        #1;
        rdy = model_ready();
        check("cfg_ready", 32'(cfg_ready), 32'(rdy));
        e_tick = '0;
        if (!rst) begin
            model_reset();
        end else begin
            v = (cfg_half == 0) ? 1 : int'(cfg_half);
            for (int i = 0; i < NCH; i++) begin
                bit acc;
                acc = cfg_valid && rdy && (int'(cfg_ch) == i);
                if (!en[i]) begin
                    if (m_pend[i]) begin
                        m_half[i] = m_shd[i];
                        m_pend[i] = 1'b0;
                    end else if (acc) begin
                        m_half[i] = v;
                    end
                    m_cnt[i] = 1;
                    m_clk[i] = 1'b0;
                end else begin
                    if (m_cnt[i] >= m_half[i]) begin
                        m_cnt[i]  = 1;
                        m_clk[i]  = !m_clk[i];
                        e_tick[i] = 1'b1;
                        if (m_pend[i]) begin
                            m_half[i] = m_shd[i];
                            m_pend[i] = 1'b0;
                        end
                    end else begin
                        m_cnt[i]++;
                    end
                    if (acc) begin
                        m_shd[i]  = v;
                        m_pend[i] = 1'b1;
                    end
                end
            end
        end
        for (int i = 0; i < NCH; i++) e_clk[i] = m_clk[i];
        sb.push_back({e_clk, e_tick});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            exp_v = sb.pop_front();
            check("clk_out", 32'(clk_out), 32'(exp_v[2*NCH-1:NCH]));
            check("tick", 32'(tick), 32'(exp_v[NCH-1:0]));
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int stalls;
        int waited;
        rst       = 1'b0;
        en        = '0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_half  = '0;
        model_reset();

        // Reset held for three cycles.
        run(3);
        check("rst_clk_out", 32'(clk_out), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd0);
        rst = 1'b1;

        // Defaults: channel 0 rises at enabled edge 5, falls at 10.
        en = 5'b00001;
        run(4);
        check("t1_low_e4", 32'(clk_out[0]), 32'd0);
        cycle();
        check("t1_rise_e5", 32'(clk_out[0]), 32'd1);
        check("t1_tick_e5", 32'(tick[0]), 32'd1);
        run(4);
        check("t1_tick_e9", 32'(tick[0]), 32'd0);
        cycle();
        check("t1_fall_e10", 32'(clk_out[0]), 32'd0);
        check("t1_others", 32'(clk_out[4:1]), 32'd0);

        // Disabled channel write applies immediately.
        cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_half = 8'd3;
        #1 check("t2_ready", 32'(cfg_ready), 32'd1);
        cycle();
        cfg_valid = 1'b0;
        en[1] = 1'b1;
        run(2);
        check("t2_low_e2", 32'(clk_out[1]), 32'd0);
        cycle();
        check("t2_rise_e3", 32'(clk_out[1]), 32'd1);
        run(3);
        check("t2_fall_e6", 32'(clk_out[1]), 32'd0);

        // Glitch-free update on channel 0: restart, write at cnt=2.
        en[0] = 1'b0;
        cycle();
        en[0] = 1'b1;
        cycle();
        cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_half = 8'd2;
        cycle();
        cfg_half = 8'd4;
        #1 check("t3_stall_ready", 32'(cfg_ready), 32'd0);
        stalls = 0;
        while (!cfg_ready && stalls < 20) begin
            cycle();
            stalls++;
        end
        check("t3_stalls", 32'(stalls), 32'd3);
        check("t3_old_toggle", 32'(clk_out[0]), 32'd1);
        cycle();
        cfg_valid = 1'b0;
        check("t3_mid", 32'(clk_out[0]), 32'd1);
        cycle();
        check("t3_half2_toggle", 32'(clk_out[0]), 32'd0);
        run(6);

        // cfg_half=0 behaves as half=1.
        cfg_valid = 1'b1; cfg_ch = 3'd3; cfg_half = 8'd0;
        cycle();
        cfg_valid = 1'b0;
        en[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("t4_tick_every", 32'(tick[3]), 32'd1);
        end

        // Out-of-range channel write is accepted and dropped.
        cfg_valid = 1'b1; cfg_ch = 3'd5; cfg_half = 8'd7;
        #1 check("t5_ready", 32'(cfg_ready), 32'd1);
        cycle();
        cfg_valid = 1'b0;
        run(12);

        // Write landing exactly on a channel 1 terminal edge.
        waited = 0;
        while (m_cnt[1] < m_half[1] && waited < 20) begin
            cycle();
            waited++;
        end
        check("t6_found", 32'(waited < 20), 32'd1);
        cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_half = 8'd6;
        cycle();
        cfg_valid = 1'b0;
        check("t6_term_tick", 32'(tick[1]), 32'd1);
        run(3);
        check("t6_old_period", 32'(tick[1]), 32'd1);
        run(5);
        check("t6_new_wait", 32'(tick[1]), 32'd0);
        cycle();
        check("t6_new_period", 32'(tick[1]), 32'd1);

        // Drop enable on channel 2 with a write pending.
        en[2] = 1'b1;
        run(7);
        cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_half = 8'd2;
        cycle();
        cfg_valid = 1'b0;
        en[2] = 1'b0;
        cycle();
        check("t7_forced_low", 32'(clk_out[2]), 32'd0);
        cfg_ch = 3'd2;
        #1 check("t7_pend_clr", 32'(cfg_ready), 32'd1);
        en[2] = 1'b1;
        run(2);
        check("t7_new_half", 32'(clk_out[2]), 32'd1);
        run(3);

        // Asynchronous reset mid-count.
        #2;
        rst = 1'b0;
        #1;
        check("t8_async_clk", 32'(clk_out), 32'd0);
        check("t8_async_tick", 32'(tick), 32'd0);
        check("t8_async_ready", 32'(cfg_ready), 32'd0);
        model_reset();
        run(2);
        rst = 1'b1;
        en  = 5'b11111;
        run(4);
        check("t8_def_low", 32'(clk_out), 32'd0);
        cycle();
        check("t8_def_rise", 32'(clk_out), 32'h1f);
        run(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
